// File: rtl/axis_egress_port_demux.sv
// axis_egress_port_demux
//
// Routes each packet of a single merged AXI-Stream to one of
// NUM_OF_EGRESS_PORTS egress streams. The destination is the port_id field in
// s_tuser[PORT_ID_W-1:0] of the packet's first beat; the full header tuser
// (VLAN id included) is replayed on every beat of the packet at the output.
// Packets are never split across ports. Packets whose port_id names a port
// that does not exist are consumed and discarded.
//
// Optional feature: define AXIS_EGRESS_DEMUX_DROP_CNT_EN to add a 16-bit
// saturating counter of discarded packets on port drop_cnt.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   s_tvalid/s_tready     merged input stream handshake
//   s_tdata/s_tkeep       input payload and byte enables
//   s_tlast/s_tuser       end of packet, {vlan_id, port_id} header
//   m_tvalid/m_tready     per-port output handshake (one bit per port)
//   m_tdata/m_tkeep       per-port payload, port p at [p*W +: W]
//   m_tlast/m_tuser       per-port end of packet and latched header tuser
//   drop_cnt              discarded packet count (macro builds only)

module axis_egress_port_demux #(
  parameter int DATA_SIZE           = 32,
  parameter int USER_SIZE           = 16,
  parameter int NUM_OF_EGRESS_PORTS = 3,
  parameter int PORT_ID_W           = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     s_tvalid,
  output logic                                     s_tready,
  input  logic [DATA_SIZE-1:0]                     s_tdata,
  input  logic [DATA_SIZE/8-1:0]                   s_tkeep,
  input  logic                                     s_tlast,
  input  logic [USER_SIZE-1:0]                     s_tuser,
  output logic [NUM_OF_EGRESS_PORTS-1:0]           m_tvalid,
  input  logic [NUM_OF_EGRESS_PORTS-1:0]           m_tready,
  output logic [NUM_OF_EGRESS_PORTS*DATA_SIZE-1:0] m_tdata,
  output logic [NUM_OF_EGRESS_PORTS*(DATA_SIZE/8)-1:0] m_tkeep,
  output logic [NUM_OF_EGRESS_PORTS-1:0]           m_tlast,
  output logic [NUM_OF_EGRESS_PORTS*USER_SIZE-1:0] m_tuser
`ifdef AXIS_EGRESS_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]                              drop_cnt
`endif
);

  localparam int KEEP_W = DATA_SIZE / 8;
  localparam int NP     = NUM_OF_EGRESS_PORTS;
  localparam logic [PORT_ID_W:0] NUM_PORTS_L = (PORT_ID_W + 1)'(NUM_OF_EGRESS_PORTS);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_t;

  state_t                  state_q, state_d;
  logic [USER_SIZE-1:0]    hdr_q, hdr_d;
  logic [PORT_ID_W-1:0]    sel_q, sel_d;

  logic [NP-1:0]           mTvalid_q;
  logic [NP*DATA_SIZE-1:0] mTdata_q;
  logic [NP*KEEP_W-1:0]    mTkeep_q;
  logic [NP-1:0]           mTlast_q;
  logic [NP*USER_SIZE-1:0] mTuser_q;

  logic sTready;
  logic selReady;
  logic accept;
  logic fwdAccept;

  // The selected output register can take a beat when it is empty or is
  // being drained this cycle, which gives full throughput with no skid buffer.
  always_comb begin
    selReady = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (sel_q == PORT_ID_W'(p)) begin
        selReady = ~mTvalid_q[p] | m_tready[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      sel_q   <= sel_d;
    end
  end

  // IDLE only peeks at the header beat without consuming it; the beat itself
  // is taken in FWD or DROP on the following cycle.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    sel_d   = sel_q;
    sTready = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_tvalid) begin
          hdr_d   = s_tuser;
          sel_d   = s_tuser[PORT_ID_W-1:0];
          state_d = ({1'b0, s_tuser[PORT_ID_W-1:0]} < NUM_PORTS_L) ? FWD : DROP;
        end
      end
      FWD: begin
        sTready = selReady;
        if (s_tvalid && selReady && s_tlast) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        sTready = 1'b1;
        if (s_tvalid && s_tlast) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_tready  = sTready;
  assign accept    = s_tvalid & sTready;
  assign fwdAccept = accept && (state_q == FWD);

  // A load wins over a drain, so a simultaneous load and drain keeps valid
  // high with the new beat. Unselected ports keep draining on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mTvalid_q <= '0;
      mTdata_q  <= '0;
      mTkeep_q  <= '0;
      mTlast_q  <= '0;
      mTuser_q  <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (fwdAccept && (sel_q == PORT_ID_W'(p))) begin
          mTvalid_q[p]                         <= 1'b1;
          mTdata_q[p*DATA_SIZE +: DATA_SIZE]   <= s_tdata;
          mTkeep_q[p*KEEP_W +: KEEP_W]         <= s_tkeep;
          mTlast_q[p]                          <= s_tlast;
          mTuser_q[p*USER_SIZE +: USER_SIZE]   <= hdr_q;
        end else if (m_tready[p]) begin
          mTvalid_q[p] <= 1'b0;
        end
      end
    end
  end

  assign m_tvalid = mTvalid_q;
  assign m_tdata  = mTdata_q;
  assign m_tkeep  = mTkeep_q;
  assign m_tlast  = mTlast_q;
  assign m_tuser  = mTuser_q;

`ifdef AXIS_EGRESS_DEMUX_DROP_CNT_EN
  logic [15:0] dropCnt_q;

  // Counts once per discarded packet, on its last beat; holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dropCnt_q <= '0;
    end else if (accept && (state_q == DROP) && s_tlast && (dropCnt_q != 16'hFFFF)) begin
      dropCnt_q <= dropCnt_q + 16'd1;
    end
  end

  assign drop_cnt = dropCnt_q;
`endif

endmodule
